uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx_if.sv | 10 +
 rtl/uart_tx.sv | 162 ++++++++++++++++
 tb/tb_uart_tx.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Byte-in / serial-out handshake between a byte producer and uart_tx.
interface uart_tx_if;
    logic       new_data;
    logic [7:0] data_in;
    logic       tx_busy;
    logic       tx;

    modport master (output new_data, output data_in, input tx_busy, input tx);
    modport slave  (input new_data, input data_in, output tx_busy, output tx);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even parity, 1 or 2 stop bits.
// Define UART_TX_PARITY_EN to insert the even-parity bit after data bit 7.
module uart_tx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int STOP_BITS = 1
) (
    input logic      clk,
    input logic      reset_N,
    uart_tx_if.slave bus
);
    localparam int              CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int              CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic            LAST_STOP    = (STOP_BITS == 2);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("uart_tx: CLK_FREQ/BAUD must be at least 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("uart_tx: STOP_BITS must be 1 or 2");
        end
    endgenerate

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_e;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             stop_cnt_q, stop_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic bit_done;
    assign bit_done = (cnt_q == CNT_LAST);

    // tx_d is the value of the bit that the next state will present, so tx
    // changes on the same edge as the state and stays a pure register output.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        if (state_q != IDLE) begin
            cnt_d = bit_done ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (bus.new_data && !busy_q) begin
                    state_d  = START;
                    shift_d  = bus.data_in;
                    cnt_d    = '0;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^bus.data_in;
`endif
                end
            end
            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d    = PARITY;
                        tx_d       = parity_q;
`else
                        state_d    = STOP;
                        stop_cnt_d = 1'b0;
                        tx_d       = 1'b1;
`endif
                    end else begin
                        tx_d = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_d    = STOP;
                    stop_cnt_d = 1'b0;
                    tx_d       = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                    tx_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_N) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
            shift_q    <= 8'h00;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign bus.tx      = tx_q;
    assign bus.tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: one DUT with 1 stop bit, one with 2, shared clock and reset.
module tb_uart_tx;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FRAME1 = 1 + 8 + P + 1;
    localparam int FRAME2 = 1 + 8 + P + 2;

    typedef struct {
        logic [7:0] data;
        bit         abort;
    } exp_t;

    logic clk = 1'b0;
    logic reset_N;
    int   n_cmp = 0;
    int   n_err = 0;
    int   frames_seen [2];
    exp_t q0 [$];
    exp_t q1 [$];

    uart_tx_if if1 ();
    uart_tx_if if2 ();

    uart_tx #(.CLK_FREQ(16), .BAUD(4), .STOP_BITS(1)) u_dut1 (.clk(clk), .reset_N(reset_N), .bus(if1));
    uart_tx #(.CLK_FREQ(16), .BAUD(4), .STOP_BITS(2)) u_dut2 (.clk(clk), .reset_N(reset_N), .bus(if2));

    always #5 clk = ~clk;

    logic [1:0] tx_w, busy_w;
    assign tx_w   = {if2.tx, if1.tx};
    assign busy_w = {if2.tx_busy, if1.tx_busy};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives a one-cycle request from a negedge and records what the frame must carry.
    task automatic send(input int k, input logic [7:0] d, input bit ab);
        exp_t e;
        e.data  = d;
        e.abort = ab;
        if (k == 0) begin
            q0.push_back(e);
            if1.new_data = 1'b1;
            if1.data_in  = d;
        end else begin
            q1.push_back(e);
            if2.new_data = 1'b1;
            if2.data_in  = d;
        end
        @(negedge clk);
        if (k == 0) begin
            if1.new_data = 1'b0;
            if1.data_in  = ~d;
        end else begin
            if2.new_data = 1'b0;
            if2.data_in  = ~d;
        end
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        while (busy_w[k] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("idle_timeout%0d", k), busy_w[k], 1'b0);
    endtask

    // Decodes each frame from tx: ba samples the first cycle of each bit, bb the last.
    task automatic monitor(input int k);
        logic        prev = 1'b0;
        int          len;
        int          fb;
        int          qsize;
        logic [11:0] ba, bb;
        exp_t        e;
        fb = (k == 0) ? FRAME1 : FRAME2;
        forever begin
            @(negedge clk);
            if (busy_w[k] && !prev) begin
                check($sformatf("start_with_busy%0d", k), tx_w[k], 1'b0);
                len = 0;
                ba  = '0;
                bb  = '0;
                while (busy_w[k]) begin
                    if (len < 48) begin
                        if (len % CPB == 0) ba[len / CPB] = tx_w[k];
                        if (len % CPB == CPB - 1) bb[len / CPB] = tx_w[k];
                    end
                    len++;
                    @(negedge clk);
                end
                qsize = (k == 0) ? q0.size() : q1.size();
                check($sformatf("frame_expected%0d", k), qsize > 0, 1'b1);
                if (qsize > 0) begin
                    e = (k == 0) ? q0.pop_front() : q1.pop_front();
                    if (e.abort) begin
                        check($sformatf("abort_len%0d", k), len, 18);
                    end else begin
                        frames_seen[k]++;
                        check($sformatf("busy_len%0d", k), len, fb * CPB);
                        check($sformatf("bit_hold%0d", k), ba, bb);
                        check($sformatf("start_bit%0d", k), bb[0], 1'b0);
                        check($sformatf("data%0d", k), bb[8:1], e.data);
`ifdef UART_TX_PARITY_EN
                        check($sformatf("parity%0d", k), bb[9], ^e.data);
`endif
                        check($sformatf("stop1_%0d", k), bb[9+P], 1'b1);
                        if (k == 1) check("stop2_1", bb[10+P], 1'b1);
                    end
                end
            end
            prev = busy_w[k];
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        frames_seen[0] = 0;
        frames_seen[1] = 0;
        reset_N      = 1'b0;
        if1.new_data = 1'b0;
        if1.data_in  = 8'h00;
        if2.new_data = 1'b0;
        if2.data_in  = 8'h00;

        // Reset with requests held high: requests must be ignored.
        repeat (2) @(negedge clk);
        if1.new_data = 1'b1;
        if1.data_in  = 8'hFF;
        if2.new_data = 1'b1;
        if2.data_in  = 8'hFF;
        repeat (3) @(negedge clk);
        check("rst_tx1", if1.tx, 1'b1);
        check("rst_busy1", if1.tx_busy, 1'b0);
        check("rst_tx2", if2.tx, 1'b1);
        check("rst_busy2", if2.tx_busy, 1'b0);
        if1.new_data = 1'b0;
        if2.new_data = 1'b0;
        reset_N      = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_busy1", if1.tx_busy, 1'b0);
        check("post_rst_busy2", if2.tx_busy, 1'b0);

        // Single byte on both; 2-stop-bit DUT sends 8'h00.
        send(0, 8'hA5, 1'b0);
        send(1, 8'h00, 1'b0);
        wait_idle(0);
        wait_idle(1);
        repeat (3) @(negedge clk);

        // Request while busy is dropped.
        send(0, 8'h0F, 1'b0);
        repeat (10) @(negedge clk);
        if1.new_data = 1'b1;
        if1.data_in  = 8'hFF;
        @(negedge clk);
        if1.new_data = 1'b0;
        wait_idle(0);
        repeat (60) @(negedge clk);

        // Back-to-back: request in the first idle cycle after a frame.
        send(0, 8'h81, 1'b0);
        wait_idle(0);
        send(0, 8'h3C, 1'b0);
        check("b2b_busy", if1.tx_busy, 1'b1);
        check("b2b_tx", if1.tx, 1'b0);
        wait_idle(0);
        repeat (3) @(negedge clk);

        // Reset at cycle 17 of a frame aborts it; a following frame is clean.
        send(0, 8'h55, 1'b1);
        repeat (17) @(negedge clk);
        reset_N = 1'b0;
        @(negedge clk);
        check("midrst_tx", if1.tx, 1'b1);
        check("midrst_busy", if1.tx_busy, 1'b0);
        reset_N = 1'b1;
        @(negedge clk);
        send(0, 8'h55, 1'b0);
        wait_idle(0);
        repeat (3) @(negedge clk);

        // Odd-weight byte for the parity bit.
        send(0, 8'h07, 1'b0);
        send(1, 8'h07, 1'b0);
        wait_idle(0);
        wait_idle(1);
        repeat (20) @(negedge clk);

        check("pending0", q0.size(), 0);
        check("pending1", q1.size(), 0);
        check("frames0", frames_seen[0], 6);
        check("frames1", frames_seen[1], 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
